// File: rtl/bcd_serial_sub.sv
// rtl/bcd_serial_sub.sv - digit-serial BCD subtractor, diff = a - b - bin mod 10^DIGITS, LSD first.
// Optional BCD_SUB_SIGNMAG_EN: negative results are re-negated so diff holds the magnitude and bout the sign.
module bcd_serial_sub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                bout,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_NEG
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    diff_r;
    logic [CW-1:0]   cnt;
    logic            borrow;
    logic            bout_r;
    logic            err_r;

    logic [3:0]      op_a;
    logic [3:0]      op_b;
    logic [4:0]      t;
    logic [3:0]      d;
    logic            borrow_n;
    logic            last;
    logic            in_err;

    // One digit of the subtraction; in NEG the minuend is zero and the subtrahend is the stored result.
    always_comb begin
        op_a = a_r[cnt*4 +: 4];
        op_b = b_r[cnt*4 +: 4];
`ifdef BCD_SUB_SIGNMAG_EN
        if (state == S_NEG) begin
            op_a = 4'd0;
            op_b = diff_r[cnt*4 +: 4];
        end
`endif
        t = {1'b0, op_a} - {1'b0, op_b} - {4'd0, borrow};
        if (t[4]) begin
            d        = t[3:0] + 4'd10;
            borrow_n = 1'b1;
        end else begin
            d        = t[3:0];
            borrow_n = 1'b0;
        end
    end

    assign last = (cnt == CW'(DIGITS - 1));

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) begin
                in_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
`ifdef BCD_SUB_SIGNMAG_EN
                    state_n = borrow_n ? S_NEG : S_DONE;
`else
                    state_n = S_DONE;
`endif
                end
            end
            S_NEG: begin
                if (last) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            bout_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        err_r  <= in_err;
                        bout_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    diff_r[cnt*4 +: 4] <= d;
                    borrow             <= borrow_n;
                    if (last) begin
                        cnt    <= '0;
                        bout_r <= borrow_n;
`ifdef BCD_SUB_SIGNMAG_EN
                        borrow <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_NEG: begin
                    // The final borrow of the negation is irrelevant; bout already records the sign.
                    diff_r[cnt*4 +: 4] <= d;
                    borrow             <= borrow_n;
                    cnt                <= last ? '0 : cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == S_RUN) || (state == S_NEG);
    assign done = (state == S_DONE);
    assign diff = diff_r;
    assign bout = bout_r;
    assign err  = err_r;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// tb/tb_bcd_serial_sub.sv - scoreboard bench for bcd_serial_sub with DIGITS=4.
module tb_bcd_serial_sub;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        err;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int done_cnt   = 0;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        err;
        int          lat;
        int          s;
    } exp_t;

    exp_t exp_q[$];

    bcd_serial_sub #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = exp_q.pop_front();
                check("diff", {16'd0, diff}, {16'd0, e.diff});
                check("bout", {31'd0, bout}, {31'd0, e.bout});
                check("err", {31'd0, err}, {31'd0, e.err});
                check("latency", cyc - e.s - 1, e.lat);
            end
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 40; k++) begin
            if (!busy && !done) break;
            @(negedge clk);
        end
        if (k == 40) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: busy=%0b done=%0b, expected idle within 40 cycles", busy, done);
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                          input logic [15:0] ed, input logic eb, input logic ee, input int el,
                          input int hold);
        exp_t e;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        e.diff = ed;
        e.bout = eb;
        e.err  = ee;
        e.lat  = el;
        e.s    = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        a   = 16'hFFFF;
        b   = 16'h3333;
        bin = ~tbin;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    int lat_neg;
    int d0;

    initial begin
`ifdef BCD_SUB_SIGNMAG_EN
        lat_neg = 8;
`else
        lat_neg = 4;
`endif
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_diff", {16'd0, diff}, 0);
        check("rst_bout", {31'd0, bout}, 0);
        check("rst_err", {31'd0, err}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 4, 0);
        run_op(16'h0100, 16'h0001, 1'b0, 16'h0099, 1'b0, 1'b0, 4, 0);
`ifdef BCD_SUB_SIGNMAG_EN
        run_op(16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0, lat_neg, 0);
        run_op(16'h5000, 16'h5000, 1'b1, 16'h0001, 1'b1, 1'b0, lat_neg, 0);
        run_op(16'h0250, 16'h1000, 1'b0, 16'h0750, 1'b1, 1'b0, lat_neg, 0);
`else
        run_op(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, lat_neg, 0);
        run_op(16'h5000, 16'h5000, 1'b1, 16'h9999, 1'b1, 1'b0, lat_neg, 0);
        run_op(16'h0250, 16'h1000, 1'b0, 16'h9250, 1'b1, 1'b0, lat_neg, 0);
`endif
        run_op(16'h5000, 16'h4999, 1'b0, 16'h0001, 1'b0, 1'b0, 4, 0);
        run_op(16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0, 4, 0);
        run_op(16'h00A0, 16'h0000, 1'b0, 16'h00A0, 1'b0, 1'b1, 4, 0);
        repeat (3) @(negedge clk);
        check("hold_diff", {16'd0, diff}, 32'h00A0);
        check("hold_err", {31'd0, err}, 1);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 4, 0);

        // start held high through RUN and DONE must produce exactly one result
        d0 = done_cnt;
        run_op(16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 4, 5);
        repeat (4) @(negedge clk);
        check("single_done", done_cnt - d0, 1);

        // reset two cycles into an operation aborts it with no done pulse
        d0 = done_cnt;
        @(negedge clk);
        a     = 16'h1234;
        b     = 16'h0001;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_diff", {16'd0, diff}, 0);
        check("abort_bout", {31'd0, bout}, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bcd_serial_sub.md
Name: bcd_serial_sub

Overview:
Multi-digit BCD subtractor, digit-serial, one BCD digit per clock, least significant digit first, with a start/busy/done handshake. It computes diff = a - b - bin modulo 10^DIGITS and returns the final borrow. It is the inverse arithmetic companion of the team's one-digit BCD adder, used by the decimal datapath wherever operands are too wide for a combinational chain.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0]
b  input  4*DIGITS  subtrahend, packed BCD
bin  input  1  borrow-in, applied to digit 0
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; diff/bout/err valid
diff  output  4*DIGITS  packed BCD result
bout  output  1  final borrow (1 = result negative)
err  output  1  a or b contained a digit >9 at the accepted start

Behaviour:
- Reset (rst=1 at any edge): state=IDLE; busy, done, bout, err = 0; diff = 0; digit counter = 0. Reset mid-operation aborts the operation. done is not pulsed and no partial result is exposed.
- States: IDLE, RUN, DONE (plus NEG under the optional feature).
- IDLE: at edge E0 with start=1, latch a, b, and bin into internal registers. Set borrow = bin, counter = 0, and err = OR over all digits of (a_i>9 | b_i>9). Go to RUN; busy=1 after E0. start=0 stays in IDLE.
- RUN: at each edge, digit i = counter is processed:
  - t = {0,a_i} - {0,b_i} - borrow, 5-bit two's complement.
  - If t[4]=1: d = (t + 10)[3:0], borrow = 1. Otherwise d = t[3:0], borrow = 0.
  - d is written into diff digit i; counter increments.
- After the edge processing digit DIGITS-1 (edge E_DIGITS), go to DONE.
- DONE: lasts exactly one cycle with done=1, busy=0, bout=borrow. Then go to IDLE; done returns to 0.
- Latency: start at E0, done high in the cycle after E_DIGITS.
- start is ignored while busy=1 and while in DONE. Inputs a, b, and bin may change freely after E0.
- diff, bout, and err hold their values from DONE until the next accepted start or reset.
- diff updates digit-by-digit during RUN and is valid only when done=1 or in IDLE thereafter.
- Invalid digits: err=1, but arithmetic still follows the rule above exactly, giving a deterministic result.
- err is cleared only by reset or the next accepted start.
- DIGITS=1: a single RUN cycle.

Optional Feature:
Macro: BCD_SUB_SIGNMAG_EN.
- Without the macro: a negative result is left in ten's-complement form (0 - 1 gives 9999, bout=1). Latency is always DIGITS cycles.
- With the macro: if bout would be 1 at the end of RUN, go to NEG instead of DONE.
  - NEG runs DIGITS further cycles computing 0 - diff digit-serially, using the same digit rule with borrow reset to 0. The result is written back into diff.
  - Then go to DONE with bout=1, so diff holds the magnitude and bout the sign.
  - busy stays 1 through NEG. Latency is 2*DIGITS for negative results and DIGITS otherwise.
  - Reset during NEG aborts exactly as in RUN.

Test Plan:
- DIGITS=4; a=0x1234, b=0x0567, bin=0, start pulse -> done 4 cycles after start edge, diff=0x0667, bout=0, err=0.
- a=0x0100, b=0x0001, bin=0 -> diff=0x0099, bout=0; borrow propagates across two digits.
- a=0x0000, b=0x0001, bin=0 -> without macro: diff=0x9999, bout=1, latency 4. With BCD_SUB_SIGNMAG_EN: diff=0x0001, bout=1, latency 8.
- a=0x5000, b=0x5000, bin=1 -> diff=0x9999, bout=1 (macro off); a=0x5000, b=0x4999, bin=0 -> diff=0x0001, bout=0.
- a=0x00A0, b=0x0000 -> err=1 at done. The next start with valid operands a=0x0001, b=0x0001 -> err=0, diff=0x0000.
- Start accepted, then start re-asserted while busy -> ignored, and only one done pulse. A new start with rst=1 two cycles later -> busy=0, done never pulses, diff=0, bout=0.
